// File: rtl/tex_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// tex_bus_arb_pkg
// Shared definitions for the texture bus arbiter: fixed coordinate/texel
// widths and the helpers that derive the source-index field width that is
// appended to request tags and stripped from response tags.
// -----------------------------------------------------------------------------
package tex_bus_arb_pkg;

    localparam int TEX_COORD_W = 32;
    localparam int TEX_TEXEL_W = 32;

    // Width of the source-index field carried in the tag LSBs (0 for one agent).
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Physical width for signals that would otherwise collapse to zero bits.
    function automatic int nz_width(input int w);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/tex_bus_arb_ebuf.sv
// -----------------------------------------------------------------------------
// tex_bus_arb_ebuf
// Two-entry elastic buffer with a registered output. A push while full is
// accepted when the consumer pops in the same cycle, so a streaming path never
// bubbles.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   valid_in/ready_in     producer handshake (ready_in forced low in reset)
//   data_in               producer payload
//   valid_out/ready_out   consumer handshake
//   data_out              consumer payload (stable while valid_out && !ready_out)
// -----------------------------------------------------------------------------
module tex_bus_arb_ebuf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] data_p1 [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    assign valid_out = (count != 2'd0);
    assign ready_in  = reset && ((count != 2'd2) || ready_out);
    assign push      = valid_in && ready_in;
    assign pop       = valid_out && ready_out;
    assign data_out  = data_p1[rd_ptr];

    // Stage p0 -> p1: control state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Stage p0 -> p1: payload storage (no reset, qualified by count)
    always_ff @(posedge clk) begin
        if (push) data_p1[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/tex_bus_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tex_bus_arb_rr_arbiter
// Round-robin grant over a request vector. The search starts at the priority
// pointer; the pointer moves to winner+1 only when the grant is accepted.
// Ports:
//   clk, reset     clock, asynchronous active-low reset (pointer -> 0)
//   requests       request vector
//   accept         downstream can take the granted request this cycle
//   grant_valid    at least one request is present
//   grant_index    index of the granted request
//   grant_onehot   one-hot form of grant_index (all zero when nothing granted)
// -----------------------------------------------------------------------------
module tex_bus_arb_rr_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                accept,
    output logic                grant_valid,
    output logic [SEL_W-1:0]    grant_index,
    output logic [NUM_REQS-1:0] grant_onehot
);

    logic [SEL_W-1:0] ptr;
    logic             lo_found;
    logic             hi_found;
    logic [SEL_W-1:0] lo_idx;
    logic [SEL_W-1:0] hi_idx;

    // Two priority searches: lowest requester at/after the pointer, and the
    // lowest requester overall used when nothing at/after the pointer is valid.
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int j = NUM_REQS - 1; j >= 0; j--) begin
            if (requests[j]) begin
                lo_found = 1'b1;
                lo_idx   = SEL_W'(j);
            end
            if (requests[j] && (j >= int'(ptr))) begin
                hi_found = 1'b1;
                hi_idx   = SEL_W'(j);
            end
        end
    end

    assign grant_valid  = lo_found;
    assign grant_index  = hi_found ? hi_idx : lo_idx;
    assign grant_onehot = grant_valid ? (NUM_REQS'(1) << grant_index) : '0;

    // Stage p0 -> p1: priority pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (grant_valid && accept) begin
            ptr <= (grant_index == SEL_W'(NUM_REQS - 1)) ? '0 : grant_index + SEL_W'(1);
        end
    end

endmodule

// File: rtl/tex_bus_arb.sv
// -----------------------------------------------------------------------------
// tex_bus_arb
// Arbitrates texture requests from NUM_INPUTS agents onto one texture-unit
// request bus and routes the unit's responses back by the source index that
// was appended to the request tag. Both directions are registered through
// two-entry elastic buffers.
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   in_req_*  / in_req_ready           per-agent request channels
//   out_req_* / out_req_ready          unit request channel, tag = {tag, src}
//   in_rsp_*  / in_rsp_ready           unit response channel
//   out_rsp_* / out_rsp_ready          per-agent response channels
// -----------------------------------------------------------------------------
module tex_bus_arb
    import tex_bus_arb_pkg::*;
#(
    parameter int  NUM_INPUTS = 4,
    parameter int  NUM_LANES  = 4,
    parameter int  TAG_WIDTH  = 16,
    parameter int  LOD_BITS   = 4,
    parameter int  STAGE_BITS = 2,
    localparam int SEL_BITS   = log2up(NUM_INPUTS)
) (
    input  logic                                                       clk,
    input  logic                                                       reset,

    input  logic [NUM_INPUTS-1:0]                                      in_req_valid,
    input  logic [NUM_INPUTS-1:0][NUM_LANES-1:0]                       in_req_mask,
    input  logic [NUM_INPUTS-1:0][1:0][NUM_LANES-1:0][TEX_COORD_W-1:0] in_req_coords,
    input  logic [NUM_INPUTS-1:0][NUM_LANES-1:0][LOD_BITS-1:0]         in_req_lod,
    input  logic [NUM_INPUTS-1:0][STAGE_BITS-1:0]                      in_req_stage,
    input  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]                       in_req_tag,
    output logic [NUM_INPUTS-1:0]                                      in_req_ready,

    output logic                                                       out_req_valid,
    input  logic                                                       out_req_ready,
    output logic [NUM_LANES-1:0]                                       out_req_mask,
    output logic [1:0][NUM_LANES-1:0][TEX_COORD_W-1:0]                 out_req_coords,
    output logic [NUM_LANES-1:0][LOD_BITS-1:0]                         out_req_lod,
    output logic [STAGE_BITS-1:0]                                      out_req_stage,
    output logic [TAG_WIDTH+SEL_BITS-1:0]                              out_req_tag,

    input  logic                                                       in_rsp_valid,
    output logic                                                       in_rsp_ready,
    input  logic [NUM_LANES-1:0][TEX_TEXEL_W-1:0]                      in_rsp_texels,
    input  logic [TAG_WIDTH+SEL_BITS-1:0]                              in_rsp_tag,

    output logic [NUM_INPUTS-1:0]                                      out_rsp_valid,
    input  logic [NUM_INPUTS-1:0]                                      out_rsp_ready,
    output logic [NUM_INPUTS-1:0][NUM_LANES-1:0][TEX_TEXEL_W-1:0]      out_rsp_texels,
    output logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]                       out_rsp_tag
);

    localparam int SEL_W     = nz_width(SEL_BITS);
    localparam int OUT_TAG_W = TAG_WIDTH + SEL_BITS;
    localparam int REQ_W     = NUM_LANES + 2 * NUM_LANES * TEX_COORD_W
                             + NUM_LANES * LOD_BITS + STAGE_BITS + OUT_TAG_W;
    localparam int RSP_W     = NUM_LANES * TEX_TEXEL_W + TAG_WIDTH;

    // ---------------- request path ----------------
    logic                  grant_valid;
    logic [SEL_W-1:0]      grant_idx;
    logic [NUM_INPUTS-1:0] grant_onehot;
    logic                  req_buf_ready;
    logic [OUT_TAG_W-1:0]  grant_tag;
    logic [REQ_W-1:0]      req_data_p0;
    logic [REQ_W-1:0]      req_data_p1;

    tex_bus_arb_rr_arbiter #(
        .NUM_REQS (NUM_INPUTS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .requests     (in_req_valid),
        .accept       (req_buf_ready),
        .grant_valid  (grant_valid),
        .grant_index  (grant_idx),
        .grant_onehot (grant_onehot)
    );

    generate
        if (SEL_BITS > 0) begin : g_req_tag_sel
            assign grant_tag = {in_req_tag[grant_idx], grant_idx[SEL_BITS-1:0]};
        end else begin : g_req_tag_nosel
            assign grant_tag = in_req_tag[grant_idx];
        end
    endgenerate

    assign req_data_p0 = {in_req_mask[grant_idx], in_req_coords[grant_idx],
                          in_req_lod[grant_idx], in_req_stage[grant_idx], grant_tag};

    // Only the granted agent sees ready, and only when the buffer can take it.
    assign in_req_ready = grant_onehot & {NUM_INPUTS{req_buf_ready}};

    // Stage p0 -> p1: request buffer
    tex_bus_arb_ebuf #(
        .DATA_W (REQ_W)
    ) u_req_buf (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (grant_valid),
        .ready_in  (req_buf_ready),
        .data_in   (req_data_p0),
        .valid_out (out_req_valid),
        .ready_out (out_req_ready),
        .data_out  (req_data_p1)
    );

    assign {out_req_mask, out_req_coords, out_req_lod, out_req_stage, out_req_tag} = req_data_p1;

    // ---------------- response path ----------------
    logic [SEL_W-1:0]      rsp_sel;
    logic                  rsp_sel_legal;
    logic [TAG_WIDTH-1:0]  rsp_agent_tag;
    logic [NUM_INPUTS-1:0] rsp_buf_ready;

    generate
        if (SEL_BITS > 0) begin : g_rsp_sel
            assign rsp_sel = in_rsp_tag[SEL_BITS-1:0];
        end else begin : g_rsp_nosel
            assign rsp_sel = '0;
        end
    endgenerate

    assign rsp_agent_tag = in_rsp_tag[SEL_BITS +: TAG_WIDTH];
    assign rsp_sel_legal = (32'(rsp_sel) < 32'(NUM_INPUTS));

    // Out-of-range indices are swallowed so the unit bus cannot lock up.
    assign in_rsp_ready = rsp_sel_legal ? rsp_buf_ready[rsp_sel] : reset;

    generate
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_rsp
            logic [RSP_W-1:0] rsp_data_p1;

            // Stage p0 -> p1: per-agent response buffer
            tex_bus_arb_ebuf #(
                .DATA_W (RSP_W)
            ) u_rsp_buf (
                .clk       (clk),
                .reset     (reset),
                .valid_in  (in_rsp_valid && rsp_sel_legal && (rsp_sel == SEL_W'(i))),
                .ready_in  (rsp_buf_ready[i]),
                .data_in   ({in_rsp_texels, rsp_agent_tag}),
                .valid_out (out_rsp_valid[i]),
                .ready_out (out_rsp_ready[i]),
                .data_out  (rsp_data_p1)
            );

            assign {out_rsp_texels[i], out_rsp_tag[i]} = rsp_data_p1;
        end
    endgenerate

    rsp_sel_in_range: assert property (@(posedge clk) disable iff (!reset)
        in_rsp_valid |-> rsp_sel_legal);

endmodule
